// File: rtl/shift_pkg.sv
// shift_pkg: operation codes and bit-reverse helper shared by shift_rot_pipe and its stages.
package shift_pkg;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  function automatic logic [63:0] bit_rev(input logic [63:0] d, input int w);
    bit_rev = '0;
    for (int i = 0; i < w; i++) bit_rev[i] = d[w-1-i];
  endfunction
  function automatic logic is_right(input logic [2:0] op);
    return op == OP_SRL || op == OP_SRA || op == OP_ROR;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one registered 2^K level of the left-shift datapath with load-on-advance handshake.
// Carry tracking is built only when SHIFT_FLAGS_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K = 0,
  localparam int SAW = $clog2(WIDTH),
  localparam int S = 1 << K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SAW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic             in_fill,
`ifdef SHIFT_FLAGS_EN
  input  logic             in_carry,
  output logic             out_carry,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SAW-1:0]   out_amt,
  output logic [2:0]       out_op,
  output logic             out_fill
);
  logic do_sh;
  logic [WIDTH-1:0] shifted;
  // reserved op codes never shift, so they pass through with carry untouched (0)
  assign do_sh = in_amt[K] && in_op <= OP_ROR;
  assign shifted = {in_data[WIDTH-S-1:0],
                    (in_op == OP_ROL || in_op == OP_ROR) ? in_data[WIDTH-1:WIDTH-S] : {S{in_fill}}};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_op    <= OP_SLL;
      out_fill  <= 1'b0;
`ifdef SHIFT_FLAGS_EN
      out_carry <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= do_sh ? shifted : in_data;
      out_amt   <= in_amt;
      out_op    <= in_op;
      out_fill  <= in_fill;
`ifdef SHIFT_FLAGS_EN
      out_carry <= do_sh ? in_data[WIDTH-S] : in_carry;
`endif
    end
  end
endmodule

// File: rtl/shift_rot_pipe.sv
// shift_rot_pipe: pipelined SLL/ROL/SRL/SRA/ROR unit, one registered level per shift-amount bit.
// Define SHIFT_FLAGS_EN to add the out_carry / out_zero flag outputs.
module shift_rot_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SAW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SAW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_FLAGS_EN
  output logic             out_carry,
  output logic             out_zero,
`endif
  output logic [WIDTH-1:0] out_data
);
  logic [SAW:0] v_s;
  logic [SAW-1:0] adv;
  logic [WIDTH-1:0] data_s [SAW+1];
  logic [SAW-1:0] amt_s [SAW+1];
  logic [2:0] op_s [SAW+1];
  logic fill_s [SAW+1];
`ifdef SHIFT_FLAGS_EN
  logic carry_s [SAW+1];
  assign carry_s[0] = 1'b0;
`endif
  // right ops run through the left datapath on a bit-reversed operand
  assign v_s[0]    = in_valid;
  assign data_s[0] = is_right(in_op) ? WIDTH'(bit_rev(64'(in_data), WIDTH)) : in_data;
  assign amt_s[0]  = in_amt;
  assign op_s[0]   = in_op;
  assign fill_s[0] = in_op == OP_SRA && in_data[WIDTH-1];
  always_comb begin
    adv[SAW-1] = out_ready | ~v_s[SAW];
    for (int i = SAW - 2; i >= 0; i--) adv[i] = adv[i+1] | ~v_s[i+1];
  end
  assign in_ready = adv[0];
  for (genvar k = 0; k < SAW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv[k]),
      .in_valid (v_s[k]),
      .in_data  (data_s[k]),
      .in_amt   (amt_s[k]),
      .in_op    (op_s[k]),
      .in_fill  (fill_s[k]),
`ifdef SHIFT_FLAGS_EN
      .in_carry (carry_s[k]),
      .out_carry(carry_s[k+1]),
`endif
      .out_valid(v_s[k+1]),
      .out_data (data_s[k+1]),
      .out_amt  (amt_s[k+1]),
      .out_op   (op_s[k+1]),
      .out_fill (fill_s[k+1])
    );
  end
  assign out_valid = v_s[SAW];
  assign out_data  = is_right(op_s[SAW]) ? WIDTH'(bit_rev(64'(data_s[SAW]), WIDTH)) : data_s[SAW];
`ifdef SHIFT_FLAGS_EN
  assign out_carry = v_s[SAW] & carry_s[SAW];
  assign out_zero  = v_s[SAW] & ~|data_s[SAW];
`endif
endmodule

// File: tb/tb_shift_rot_pipe.sv
// tb_shift_rot_pipe: directed and randomized checks of shift_rot_pipe (WIDTH=16) against an arithmetic model.
module tb_shift_rot_pipe;
  typedef struct packed {logic [15:0] d; logic c;} exp_t;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [3:0] in_amt;
  logic [2:0] in_op;
  logic out_carry, out_zero;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t e;
  logic held = 1'b0;
  logic [15:0] hold_d, snap;
  logic done;

  shift_rot_pipe #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SHIFT_FLAGS_EN
    .out_carry(out_carry),
    .out_zero (out_zero),
`endif
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] d, input int a);
    logic [31:0] x;
    exp_t r;
    case (op)
      3'd0: begin x = {16'd0, d} << a; r.d = x[15:0]; r.c = (a != 0) && x[16]; end
      3'd1: begin x = {d, d} << a; r.d = x[31:16]; r.c = (a != 0) && r.d[0]; end
      3'd2: begin r.d = d >> a; r.c = (a != 0) && d[a-1]; end
      3'd3: begin r.d = 16'($signed(d) >>> a); r.c = (a != 0) && d[a-1]; end
      3'd4: begin x = {d, d} >> a; r.d = x[15:0]; r.c = (a != 0) && r.d[15]; end
      default: begin r.d = d; r.c = 1'b0; end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // called at posedge+2; returns at posedge+2 after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a);
    int w = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      checks++; errors++;
      $error("FAIL issue_timeout: observed in_ready %b expected 1", in_ready);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic run1(input logic [2:0] op, input logic [15:0] d, input logic [3:0] a,
                      input logic [15:0] ed, input logic ec);
    int lat = 1;
    issue(op, d, a);
    @(negedge clk);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", lat, 4);
    chk("direct_data", out_data, ed);
`ifdef SHIFT_FLAGS_EN
    chk("direct_carry", out_carry, ec);
`else
    if (ec === 1'bx) $display("note: unknown expected carry");
`endif
    @(posedge clk); #2;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (out_valid) begin
        chk("spurious_out", 32'(q.size() != 0), 1);
        if (out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("model_data", out_data, e.d);
`ifdef SHIFT_FLAGS_EN
          chk("model_carry", out_carry, e.c);
          chk("model_zero", out_zero, 32'(e.d == 16'd0));
`endif
        end
      end
      held = out_valid && !out_ready;
      hold_d = out_data;
      if (in_valid && in_ready) q.push_back(model(in_op, in_data, int'(in_amt)));
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef SHIFT_FLAGS_EN
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_zero", out_zero, 0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    run1(3'd0, 16'h8001, 4'd1, 16'h0002, 1'b1);
    run1(3'd1, 16'h8001, 4'd4, 16'h0018, 1'b0);
    run1(3'd4, 16'h0001, 4'd1, 16'h8000, 1'b1);
    run1(3'd3, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
    run1(3'd2, 16'h8000, 4'd15, 16'h0001, 1'b0);
    run1(3'd2, 16'h0001, 4'd1, 16'h0000, 1'b1);
    run1(3'd7, 16'hA5A5, 4'd7, 16'hA5A5, 1'b0);
    run1(3'd3, 16'h8001, 4'd0, 16'h8001, 1'b0);
    run1(3'd1, 16'h1234, 4'd0, 16'h1234, 1'b0);
    // stall: six back-to-back ops against a blocked consumer
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) issue(3'(i % 5), 16'($urandom), 4'($urandom_range(15)));
      begin
        repeat (5) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        snap = out_data;
        @(negedge clk);
        chk("stall_hold", out_data, snap);
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (6) begin @(negedge clk); chk("no_gap", out_valid, 1); end
      end
    join
    @(posedge clk); #2;
    // reset with three operations in flight
    repeat (3) issue(3'($urandom_range(4)), 16'($urandom), 4'($urandom_range(15)));
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    repeat (6) begin @(negedge clk); chk("post_rst_no_out", out_valid, 0); end
    @(posedge clk); #2;
    run1(3'd0, 16'h0003, 4'd2, 16'h000C, 1'b0);
    // randomized traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #2; end
          issue(3'($urandom_range(7)), 16'($urandom), 4'($urandom_range(15)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #2; out_ready = 1'($urandom_range(1)); end
        out_ready = 1'b1;
      end
    join
    for (int w = 0; w < 50 && q.size() != 0; w++) @(negedge clk);
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
